// File: rtl/booth_mul_pkg.sv
// Shared types for the sequential Booth multiplier: controller states and Booth recoding.
package booth_mul_pkg;

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    typedef enum logic [1:0] {
        NOP = 2'd0,
        ADD = 2'd1,
        SUB = 2'd2
    } booth_op_t;

    // Radix-2 Booth recoding of the current multiplier bit and the bit shifted out before it.
    function automatic booth_op_t booth_op(input logic q0, input logic q_1);
        booth_op_t op;
        case ({q0, q_1})
            2'b01:   op = ADD;
            2'b10:   op = SUB;
            default: op = NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_mul_seq_step.sv
// One combinational radix-2 Booth iteration: conditional add/sub of M into A, then an
// arithmetic right shift of {A, Q, q_1}.
module booth_step
    import booth_mul_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned QW    = WIDTH
) (
    input  logic [WIDTH:0]  i_a,
    input  logic [QW-1:0]   i_q,
    input  logic            i_q_1,
    input  logic [WIDTH:0]  i_m,
    output logic [WIDTH:0]  o_a,
    output logic [QW-1:0]   o_q,
    output logic            o_q_1
);

    logic [WIDTH:0] w_sum;

    always_comb begin
        w_sum = i_a;
        case (booth_op(i_q[0], i_q_1))
            ADD:     w_sum = i_a + i_m;
            SUB:     w_sum = i_a - i_m;
            default: w_sum = i_a;
        endcase
        o_a   = {w_sum[WIDTH], w_sum[WIDTH:1]};
        o_q   = {w_sum[0], i_q[QW-1:1]};
        o_q_1 = i_q[0];
    end

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative radix-2 Booth multiplier, one step per clock, start/done handshake.
// Define BOOTH_MUL_UNSIGNED_EN to add i_is_signed and run WIDTH+1 steps on extended operands.
module booth_mul_seq
    import booth_mul_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH + 2)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_start,
`ifdef BOOTH_MUL_UNSIGNED_EN
    input  logic                 i_is_signed,
`endif
    input  logic [WIDTH-1:0]     i_mplr,
    input  logic [WIDTH-1:0]     i_mcnd,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_product
);

`ifdef BOOTH_MUL_UNSIGNED_EN
    localparam int unsigned QW = WIDTH + 1;
`else
    localparam int unsigned QW = WIDTH;
`endif
    localparam int unsigned NSTEP = QW;
    // Number of A bits that land in the low 2*WIDTH bits of {A, Q}.
    localparam int unsigned AL    = 2 * WIDTH - QW;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSTEP - 1);

    state_t               r_state;
    logic [WIDTH:0]       r_a;
    logic [QW-1:0]        r_q;
    logic                 r_q_1;
    logic [WIDTH:0]       r_m;
    logic [CNT_W-1:0]     r_count;
    logic                 r_busy;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_product;

    logic [WIDTH:0]       w_a_nxt;
    logic [QW-1:0]        w_q_nxt;
    logic                 w_q_1_nxt;
    logic [WIDTH:0]       w_m_ext;
    logic [QW-1:0]        w_q_ext;

`ifdef BOOTH_MUL_UNSIGNED_EN
    assign w_m_ext = {i_is_signed & i_mcnd[WIDTH-1], i_mcnd};
    assign w_q_ext = {i_is_signed & i_mplr[WIDTH-1], i_mplr};
`else
    assign w_m_ext = {i_mcnd[WIDTH-1], i_mcnd};
    assign w_q_ext = i_mplr;
`endif

    booth_step #(
        .WIDTH (WIDTH),
        .QW    (QW)
    ) u_step (
        .i_a   (r_a),
        .i_q   (r_q),
        .i_q_1 (r_q_1),
        .i_m   (r_m),
        .o_a   (w_a_nxt),
        .o_q   (w_q_nxt),
        .o_q_1 (w_q_1_nxt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_q       <= '0;
            r_q_1     <= 1'b0;
            r_m       <= '0;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_a     <= '0;
                        r_q     <= w_q_ext;
                        r_q_1   <= 1'b0;
                        r_m     <= w_m_ext;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_a     <= w_a_nxt;
                    r_q     <= w_q_nxt;
                    r_q_1   <= w_q_1_nxt;
                    r_count <= r_count + CNT_W'(1);
                    if (r_count == LAST) begin
                        r_product <= {w_a_nxt[AL-1:0], w_q_nxt};
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_product = r_product;

endmodule
